// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg: two-entry (MAIN + SKID) valid/ready pipeline stage register
// Optional perf counters enabled by macro PIPE_STAGE_PERF_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  localparam logic [1:0] c_empty = 2'd0;
  localparam logic [1:0] c_one   = 2'd1;
  localparam logic [1:0] c_two   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic              w_main_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_main_valid = (state_q != c_empty);
  assign w_in_xfer    = in_valid & in_ready_q;
  assign w_out_xfer   = w_main_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= c_empty;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next-state logic; flush squashes both entries and any same-cycle input
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = c_empty;
    end else begin
      case (state_q)
        c_empty: if (w_in_xfer) state_d = c_one;
        c_one: begin
          if (w_in_xfer && !w_out_xfer)      state_d = c_two;
          else if (!w_in_xfer && w_out_xfer) state_d = c_empty;
        end
        c_two:   if (w_out_xfer) state_d = c_one;
        default: state_d = c_empty;
      endcase
    end
    // in_ready comes straight from a flop, so it is precomputed from state_d
    in_ready_d = (state_d != c_two);
  end

  // Payload next values
  always_comb begin
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (!flush) begin
      case (state_q)
        c_empty: begin
          if (w_in_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        c_one: begin
          if (w_in_xfer && w_out_xfer) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (w_in_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end
        end
        c_two: begin
          if (w_out_xfer) begin
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  // Outputs; control is zeroed on bubbles so downstream sees no side effect
  always_comb begin
    out_valid = w_main_valid;
    out_data  = main_data_q;
    out_ctrl  = w_main_valid ? main_ctrl_q : '0;
    in_ready  = in_ready_q;
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (w_main_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (!w_main_valid && (bubble_cnt_q != 32'hFFFF_FFFF))
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
